parity_mem_datapath: RTL and testbench
======================================

// Module: parity_mem_datapath
// PURPOSE
// - Odd-parity protected storage path: a generator, a small word memory and a checker.
// - Generator computes an odd-parity bit over DIN; the memory stores {DIN, parity} per address.
// - Checker recomputes parity over the read word and flags corruption.
// - Sits between the data producer and the read-side error-flag logic; PERR feeds that logic.
// PARAMETERS
// - DATA_W  8   data width in bits
// - ADDR_W  4   address width; DEPTH = 2**ADDR_W words
// PORTS
// - CLK    in   1       single clock, all state updates on rising edge
// - RST_N  in   1       synchronous active-low reset, sampled on rising CLK
// - WRITE  in   1       active-low write strobe
// - READ   in   1       active-low read strobe
// - ADDR   in   ADDR_W  word address for read and write
// - DIN    in   DATA_W  write data
// - INJ    in   1       fault injection: 1 = store inverted parity bit on this write
// - PGEN   out  1       combinational generated parity of DIN
// - DOUT   out  DATA_W  registered read data
// - POUT   out  1       registered stored parity bit of the read word
// - DVALID out  1       1 for the cycle after an accepted read
// - PCHK   out  1       combinational checker: XOR of {DOUT, POUT}; 1 = odd weight = good
// - PERR   out  1       DVALID & ~PCHK
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-low.
// - Parity generation: PGEN = ~^DIN, so {DIN, PGEN} always has an odd number of ones.
// - Write:
//   - On a rising edge with WRITE == 0, mem[ADDR] <= {DIN, PGEN ^ INJ}.
//   - INJ is ignored when WRITE == 1.
// - Read:
//   - On a rising edge with READ == 0, {DOUT, POUT} <= mem[ADDR] and DVALID <= 1.
//   - Latency is 1 cycle.
// - Idle (READ == 1): DOUT and POUT hold their last value; DVALID <= 0.
// - Simultaneous READ == 0 and WRITE == 0:
//   - Both are performed.
//   - The read returns the pre-write contents (read-before-write), including when ADDR matches.
// - Checker: PCHK = ^{DOUT, POUT}, purely combinational, always valid.
// - Error flag: PERR is qualified by DVALID only; no error is flagged while idle.
// - Reset (RST_N == 0 at a rising edge):
//   - Every mem word <= {0, 1} (a valid odd word).
//   - DOUT <= 0, POUT <= 1, DVALID <= 0; therefore PERR = 0 and PCHK = 1.
//   - Reset overrides any READ or WRITE in the same cycle.
//   - Reset mid-sequence discards all stored data.
// - Address space: no wrap-around or out-of-range case; every ADDR value addresses a real word.
// - All arithmetic is pure XOR reduction; no width extension.
// TESTING
// - Write 8'h24 to addr 3 (INJ=0), PGEN=1 during the write; read addr 3
//   -> DOUT=8'h24, POUT=1, DVALID=1, PCHK=1, PERR=0.
// - Write 8'h07 to addr 0, PGEN=0 during the write; read addr 0
//   -> DOUT=8'h07, POUT=0, PCHK=1, PERR=0.
// - Write 8'h5A to addr 7 with INJ=1; read addr 7
//   -> DOUT=8'h5A, POUT=0, PCHK=0, PERR=1; next idle cycle -> DVALID=0, PERR=0.
// - Addr 5 holds 8'h11; in one cycle WRITE=0 with 8'h22 and READ=0 at addr 5
//   -> DOUT=8'h11; a following read -> DOUT=8'h22.
// - Write 8'hFF to addr 2, pulse RST_N low for one cycle, then read addr 2
//   -> DOUT=8'h00, POUT=1, PERR=0.
// - Random sweep: 10 random DIN values, each written then read with INJ=0
//   -> DOUT matches DIN and PERR=0 every read.

Source files
------------

// File: rtl/parity_mem_datapath.sv
// rtl/parity_mem_datapath.sv - odd-parity generator, word memory and read-side checker
module parity_mem_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              WRITE,
    input  logic              READ,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DIN,
    input  logic              INJ,
    output logic              PGEN,
    output logic [DATA_W-1:0] DOUT,
    output logic              POUT,
    output logic              DVALID,
    output logic              PCHK,
    output logic              PERR
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W:0]   mem_q [DEPTH];
    logic [DATA_W:0]   wr_word_d;
    logic [DATA_W-1:0] dout_q;
    logic              pout_q;
    logic              dvalid_q;

    assign PGEN      = ~^DIN;
    assign wr_word_d = {DIN, PGEN ^ INJ};

    // Non-blocking read and write in the same block give read-before-write on a shared address.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {{DATA_W{1'b0}}, 1'b1};
            end
            dout_q   <= '0;
            pout_q   <= 1'b1;
            dvalid_q <= 1'b0;
        end else begin
            if (!WRITE) begin
                mem_q[ADDR] <= wr_word_d;
            end
            if (!READ) begin
                {dout_q, pout_q} <= mem_q[ADDR];
                dvalid_q         <= 1'b1;
            end else begin
                dvalid_q <= 1'b0;
            end
        end
    end

    assign DOUT   = dout_q;
    assign POUT   = pout_q;
    assign DVALID = dvalid_q;
    assign PCHK   = ^{dout_q, pout_q};
    assign PERR   = dvalid_q & ~PCHK;
endmodule

// File: tb/tb_parity_mem_datapath.sv
// tb/tb_parity_mem_datapath.sv - directed and random checks of the parity storage path
module tb_parity_mem_datapath;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              WRITE;
    logic              READ;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] DIN;
    logic              INJ;
    logic              PGEN;
    logic [DATA_W-1:0] DOUT;
    logic              POUT;
    logic              DVALID;
    logic              PCHK;
    logic              PERR;

    int compared   = 0;
    int mismatched = 0;

    // Reference state: stored data and stored parity bit per address, plus expected outputs.
    logic [DATA_W-1:0] m_data [DEPTH];
    logic              m_par  [DEPTH];
    logic [DATA_W-1:0] e_dout;
    logic              e_pout;
    logic              e_dvalid;

    parity_mem_datapath #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .WRITE(WRITE), .READ(READ), .ADDR(ADDR),
        .DIN(DIN), .INJ(INJ), .PGEN(PGEN), .DOUT(DOUT), .POUT(POUT),
        .DVALID(DVALID), .PCHK(PCHK), .PERR(PERR)
    );

    always #5 CLK = ~CLK;

    function automatic logic odd_fix(input logic [DATA_W-1:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        logic good;
        good = ($countones({e_dout, e_pout}) % 2) == 1;
        chk({tag, ".dout"},   32'(DOUT),   32'(e_dout));
        chk({tag, ".pout"},   32'(POUT),   32'(e_pout));
        chk({tag, ".dvalid"}, 32'(DVALID), 32'(e_dvalid));
        chk({tag, ".pchk"},   32'(PCHK),   32'(good));
        chk({tag, ".perr"},   32'(PERR),   32'(e_dvalid & ~good));
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i] = '0;
            m_par[i]  = 1'b1;
        end
        e_dout   = '0;
        e_pout   = 1'b1;
        e_dvalid = 1'b0;
    endtask

    // One clock: drive at the falling edge, check PGEN, clock, update model, check outputs.
    task automatic cyc(input string tag, input logic rst_n, input logic wr_n, input logic rd_n,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic inj);
        @(negedge CLK);
        RST_N = rst_n; WRITE = wr_n; READ = rd_n; ADDR = a; DIN = d; INJ = inj;
        #1;
        chk({tag, ".pgen"}, 32'(PGEN), 32'(odd_fix(d)));
        @(posedge CLK);
        if (!rst_n) begin
            model_reset();
        end else begin
            e_dvalid = !rd_n;
            if (!rd_n) begin
                e_dout = m_data[a];
                e_pout = m_par[a];
            end
            if (!wr_n) begin
                m_data[a] = d;
                m_par[a]  = odd_fix(d) ^ inj;
            end
        end
        #1;
        check_outs(tag);
    endtask

    initial begin
        logic [DATA_W-1:0] rd;
        logic [ADDR_W-1:0] ra;
        RST_N = 1'b0; WRITE = 1'b1; READ = 1'b1; ADDR = '0; DIN = '0; INJ = 1'b0;
        model_reset();

        cyc("reset", 1'b0, 1'b1, 1'b1, 4'd0, 8'h00, 1'b0);
        cyc("reset_ovr", 1'b0, 1'b0, 1'b0, 4'd1, 8'h33, 1'b1);
        cyc("rd_after_rst", 1'b1, 1'b1, 1'b0, 4'd1, 8'h00, 1'b0);

        cyc("wr24", 1'b1, 1'b0, 1'b1, 4'd3, 8'h24, 1'b0);
        cyc("rd24", 1'b1, 1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
        cyc("wr07", 1'b1, 1'b0, 1'b1, 4'd0, 8'h07, 1'b0);
        cyc("rd07", 1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0);

        cyc("wr5a_inj", 1'b1, 1'b0, 1'b1, 4'd7, 8'h5A, 1'b1);
        cyc("rd5a_inj", 1'b1, 1'b1, 1'b0, 4'd7, 8'h00, 1'b0);
        cyc("idle_after_err", 1'b1, 1'b1, 1'b1, 4'd7, 8'h00, 1'b0);

        cyc("inj_no_write", 1'b1, 1'b1, 1'b1, 4'd0, 8'h07, 1'b1);
        cyc("rd07_again", 1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0);

        cyc("wr11", 1'b1, 1'b0, 1'b1, 4'd5, 8'h11, 1'b0);
        cyc("rbw", 1'b1, 1'b0, 1'b0, 4'd5, 8'h22, 1'b0);
        cyc("rd22", 1'b1, 1'b1, 1'b0, 4'd5, 8'h00, 1'b0);

        cyc("wrff", 1'b1, 1'b0, 1'b1, 4'd2, 8'hFF, 1'b0);
        cyc("mid_reset", 1'b0, 1'b1, 1'b1, 4'd2, 8'h00, 1'b0);
        cyc("rd_cleared", 1'b1, 1'b1, 1'b0, 4'd2, 8'h00, 1'b0);

        for (int i = 0; i < 10; i++) begin
            rd = DATA_W'($urandom);
            ra = ADDR_W'($urandom);
            cyc("sweep_wr", 1'b1, 1'b0, 1'b1, ra, rd, 1'b0);
            cyc("sweep_rd", 1'b1, 1'b1, 1'b0, ra, 8'h00, 1'b0);
            chk("sweep_match", 32'(DOUT), 32'(rd));
        end

        for (int i = 0; i < 60; i++) begin
            cyc("mixed", 1'b1, 1'($urandom), 1'($urandom), ADDR_W'($urandom),
                DATA_W'($urandom), ($urandom_range(3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
